serial_sub: RTL
===============

Name: serial_sub

Overview:
- Multi-cycle digit-serial subtractor for the datapath component library.
- Inverse-direction companion to the single-cycle adder component: computes diff = a - b over DATAWIDTH/DIGITWIDTH clock cycles.
- Trades latency for area in scheduled datapaths.
- Driven by the controller FSM through a start/busy/done handshake.

Parameters:
- DATAWIDTH, 8, operand and result width in bits.
- DIGITWIDTH, 2, bits processed per cycle. DATAWIDTH must be an integer multiple of DIGITWIDTH; elaboration error otherwise.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  DATAWIDTH  minuend, unsigned; latched on accepted start.
- b  input  DATAWIDTH  subtrahend, unsigned; latched on accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when diff/borrow are valid.
- diff  output  DATAWIDTH  result, a - b modulo 2^DATAWIDTH.
- borrow  output  1  1 when a < b (unsigned underflow).

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on Rst.
- Reset (Rst=0, any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, borrow=0.
  - Internal shift registers, digit counter and borrow flop all clear.
  - Any operation in flight is discarded.
- NDIG = DATAWIDTH/DIGITWIDTH.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a and b into shift registers, clears the carry-borrow flop and count, and moves to RUN.
  - busy rises the following cycle.
- RUN, each cycle:
  - Subtract the low DIGITWIDTH bits of each shift register, together with the borrow flop.
  - Shift the resulting digit into the MSB end of the result register.
  - Shift both operand registers right by DIGITWIDTH.
  - Update the borrow flop and increment count.
  - When count reaches NDIG-1, move to DONE.
- DONE (exactly one cycle):
  - done=1 and busy=0.
  - diff is loaded from the result register; borrow is loaded from the final borrow flop.
  - start=1 in DONE behaves as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start sampled at edge N. busy is high for edges N+1..N+NDIG; done is high after edge N+NDIG+1. Throughput is one result per NDIG+1 cycles.
- diff and borrow hold their last value until the next DONE; they are not cleared by a new start.
- start asserted during RUN is ignored. No queuing; operands a and b may change freely during RUN.
- Arithmetic:
  - Unsigned, modulo 2^DATAWIDTH.
  - The digit step is {bout, d} = x - y - bin, computed at DIGITWIDTH+1 bits.
  - a == b gives diff=0, borrow=0.
- NDIG=1 is legal: RUN lasts one cycle.

Optional Feature:
- Macro: SERIAL_SUB_SAT_EN.
- Defined: in DONE, if the final borrow=1, diff is forced to 0 (unsigned saturation). borrow is still reported as 1.
- Undefined: diff wraps modulo 2^DATAWIDTH.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Localparam function computing NDIG.
  - Counter-width helper (clog2 of NDIG, minimum 1).
- One sub-module, digit_sub: combinational DIGITWIDTH-bit subtract with borrow-in and borrow-out, instantiated once in the RUN datapath.
- Everything else stays in serial_sub.

Test Plan (DATAWIDTH=8, DIGITWIDTH=2 unless stated):
- a=0x5A, b=0x13, start pulse -> busy high for 4 cycles, then done pulse with diff=0x47, borrow=0.
- a=0x10, b=0x20 -> diff=0xF0, borrow=1. With SERIAL_SUB_SAT_EN: diff=0x00, borrow=1.
- a=0xFF, b=0xFF, then start held high through DONE with new a=0x00, b=0x01 -> first result diff=0x00, borrow=0; second starts without an IDLE cycle and gives diff=0xFF, borrow=1.
- start re-pulsed and a/b changed in the 2nd RUN cycle -> ignored; the original result is produced on schedule.
- Rst driven low in the 3rd RUN cycle, asynchronously between edges -> busy, done, diff and borrow go to 0 immediately; state is IDLE after release; a new start gives a correct result.
- DATAWIDTH=8, DIGITWIDTH=8: a=0x03, b=0x05 -> busy for 1 cycle, done with diff=0xFE, borrow=1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int ndig(input int dw, input int gw);
    return dw / gw;
  endfunction
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: start/busy/done handshake plus operand and result bus for serial_sub.
interface serial_sub_if #(parameter int DATAWIDTH = 8);
  logic start;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic busy;
  logic done;
  logic [DATAWIDTH-1:0] diff;
  logic borrow;
  modport master(output start, a, b, input busy, done, diff, borrow);
  modport slave(input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_sub_digit_sub.sv
// digit_sub: combinational W-bit subtract with borrow-in and borrow-out.
module digit_sub #(parameter int W = 2) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);
  logic [W:0] r;
  assign r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
  assign d = r[W-1:0];
  assign bout = r[W];
endmodule

// File: rtl/serial_sub.sv
// serial_sub: digit-serial a - b over DATAWIDTH/DIGITWIDTH cycles with start/busy/done handshake.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero on unsigned underflow.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int DIGITWIDTH = 2
) (
  input logic Clk,
  input logic Rst,
  serial_sub_if.slave bus
);
  localparam int NDIG = ndig(DATAWIDTH, DIGITWIDTH);
  localparam int CW = cnt_w(NDIG);
  if (DATAWIDTH % DIGITWIDTH != 0) begin : g_bad_width
    $error("serial_sub: DATAWIDTH must be a multiple of DIGITWIDTH");
  end
  state_t state, nxt;
  logic [DATAWIDTH-1:0] xa, xb, res;
  logic [CW-1:0] cnt;
  logic bf, bout, last, load;
  logic [DIGITWIDTH-1:0] d;
  digit_sub #(.W(DIGITWIDTH)) u_digit (
    .x(xa[DIGITWIDTH-1:0]),
    .y(xb[DIGITWIDTH-1:0]),
    .bin(bf),
    .d(d),
    .bout(bout)
  );
  always_comb begin
    last = cnt == CW'(NDIG - 1);
    load = state != RUN && bus.start;
    nxt = (state == RUN) ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      xa <= '0;
      xb <= '0;
      res <= '0;
      cnt <= '0;
      bf <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.borrow <= 1'b0;
    end else begin
      state <= nxt;
      bus.busy <= state == RUN;
      bus.done <= state == DONE;
      if (load) begin
        xa <= bus.a;
        xb <= bus.b;
        bf <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        xa <= xa >> DIGITWIDTH;
        xb <= xb >> DIGITWIDTH;
        res <= (res >> DIGITWIDTH) | (DATAWIDTH'(d) << (DATAWIDTH - DIGITWIDTH));
        bf <= bout;
        cnt <= cnt + CW'(1);
      end
      // result capture reads the pre-load borrow flop, so back-to-back starts are safe
      if (state == DONE) begin
`ifdef SERIAL_SUB_SAT_EN
        bus.diff <= bf ? '0 : res;
`else
        bus.diff <= res;
`endif
        bus.borrow <= bf;
      end
    end
  end
endmodule
